// File: rtl/sum_window_stats_if.sv
// Sample stream in and result byte stream out of the window statistics stage.
// master = the statistics block; slave = whoever feeds samples and drains bytes.
interface sum_window_stats_if;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        input  sum_in,
        input  sum_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last
    );

    modport slave (
        output sum_in,
        output sum_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/sum_window_stats.sv
// Windowed total/min/max of the adder sum stream; each finished window is held in a
// one-deep result buffer and streamed out as four bytes while the next window accumulates.
module sum_window_stats #(
    parameter int WINDOW = 8
) (
    input  logic                clk,
    input  logic                rst,
    sum_window_stats_if.master  bus,
    input  logic                clear,
    output logic                overrun,
    output logic [7:0]          win_count
);

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } state_t;

    // Accumulation state
    logic [15:0] acc_reg;
    logic [7:0]  cnt_reg;
    logic [7:0]  min_reg;
    logic [7:0]  max_reg;

    // Readout state
    state_t      state_reg, state_next;
    logic [31:0] res_reg, res_next;
    logic [7:0]  out_data_reg, out_data_next;
    logic        out_valid_reg, out_valid_next;
    logic        out_last_reg, out_last_next;
    logic        overrun_reg, overrun_next;

    logic        accept;
    logic        first;
    logic        complete;
    logic        hs;
    logic        buf_free;
    logic        load;
    logic [15:0] total_fin;
    logic [7:0]  min_fin;
    logic [7:0]  max_fin;
    logic [7:0]  res_byte [4];

    assign accept    = bus.sum_valid && !clear;
    assign first     = (cnt_reg == 8'd0);
    assign complete  = accept && (cnt_reg == LAST_IDX);
    assign total_fin = acc_reg + {8'h00, bus.sum_in};

    // The window's first sample seeds min/max regardless of the stale register contents.
    assign min_fin = (first || (bus.sum_in < min_reg)) ? bus.sum_in : min_reg;
    assign max_fin = (first || (bus.sum_in > max_reg)) ? bus.sum_in : max_reg;

    assign hs       = out_valid_reg && bus.out_ready;
    assign buf_free = (state_reg == IDLE) || ((state_reg == B3) && hs);
    assign load     = complete && buf_free;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_reg <= 16'd0;
            cnt_reg <= 8'd0;
            min_reg <= 8'd0;
            max_reg <= 8'd0;
        end else if (accept) begin
            if (complete) begin
                acc_reg <= 16'd0;
                cnt_reg <= 8'd0;
                min_reg <= 8'd0;
                max_reg <= 8'd0;
            end else begin
                acc_reg <= total_fin;
                cnt_reg <= cnt_reg + 8'd1;
                min_reg <= min_fin;
                max_reg <= max_fin;
            end
        end
    end

    // Byte view of the next buffer contents, in readout order B0..B3.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_res_byte
            assign res_byte[gi] = res_next[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        res_next     = res_reg;
        overrun_next = overrun_reg;

        if (load) begin
            state_next = B0;
            res_next   = {max_fin, min_fin, total_fin};
        end else if (hs) begin
            case (state_reg)
                B0:      state_next = B1;
                B1:      state_next = B2;
                B2:      state_next = B3;
                B3:      state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        if (clear) begin
            overrun_next = 1'b0;
        end else if (complete && !buf_free) begin
            overrun_next = 1'b1;
        end

        // Outputs are registered from the next state so they track the FSM with no extra delay.
        out_valid_next = (state_next != IDLE);
        out_last_next  = (state_next == B3);
        case (state_next)
            B0:      out_data_next = res_byte[0];
            B1:      out_data_next = res_byte[1];
            B2:      out_data_next = res_byte[2];
            B3:      out_data_next = res_byte[3];
            default: out_data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            res_reg       <= 32'd0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            res_reg       <= res_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign overrun       = overrun_reg;
    assign win_count     = cnt_reg;

endmodule
